// File: rtl/mod_if_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_if_if
//  Description : Instruction-memory port between the fetch stage and the
//                instruction memory / cache.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_if_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface
`default_nettype wire

// File: rtl/mod_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_if
//  Description : Instruction-fetch stage with IF/ID register, skid capture,
//                redirect squash and HLT stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_if (
    input  wire         clk,
    input  wire         rst,
    input  wire         stall,
    input  wire         taken,
    input  wire  [15:0] new_pc,
    mod_if_if.master    imem,
    output logic [15:0] instruction,
    output logic [15:0] pc,
    output logic        valid,
    output logic        halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_SQUASH = 2'd1;
    localparam logic [1:0] S_SKID   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    localparam logic [3:0]  c_HLT_OP   = 4'hF;
    localparam logic [15:0] c_RESET_PC = 16'h0000;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic [15:0] r_target,     w_target_nxt;
    logic [15:0] r_skid_instr, w_skid_instr_nxt;
    logic [15:0] r_skid_pc,    w_skid_pc_nxt;
    logic [15:0] r_instr,      w_instr_nxt;
    logic [15:0] r_pc,         w_pc_nxt;
    logic        r_valid,      w_valid_nxt;

    logic [15:0] w_pc_plus2;
    logic        w_rdata_hlt;
    logic        w_skid_hlt;

    assign w_pc_plus2  = r_fetch_pc + 16'd2;
    assign w_rdata_hlt = (imem.imem_rdata[15:12] == c_HLT_OP);
    assign w_skid_hlt  = (r_skid_instr[15:12] == c_HLT_OP);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_target_nxt     = r_target;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
        w_instr_nxt      = r_instr;
        w_pc_nxt         = r_pc;
        w_valid_nxt      = r_valid;

        if (stall) begin
            if (r_state == S_FETCH && imem.imem_valid) begin
                w_skid_instr_nxt = imem.imem_rdata;
                w_skid_pc_nxt    = w_pc_plus2;
                w_state_nxt      = S_SKID;
                if (!w_rdata_hlt) begin
                    w_fetch_pc_nxt = w_pc_plus2;
                end
            end else if (r_state == S_SQUASH && imem.imem_valid) begin
                // Abandoned-path response retires even while decode is stalled
                w_fetch_pc_nxt = r_target;
                w_state_nxt    = S_FETCH;
            end
        end else if (taken) begin
            w_valid_nxt = 1'b0;
            if (imem.imem_valid || r_state == S_SKID || r_state == S_HALT) begin
                w_fetch_pc_nxt = new_pc;
                w_state_nxt    = S_FETCH;
            end else begin
                // Request still in flight: keep address stable, remember target
                w_target_nxt = new_pc;
                w_state_nxt  = S_SQUASH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        w_instr_nxt = imem.imem_rdata;
                        w_pc_nxt    = w_pc_plus2;
                        w_valid_nxt = 1'b1;
                        if (w_rdata_hlt) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_fetch_pc_nxt = w_pc_plus2;
                        end
                    end else begin
                        w_valid_nxt = 1'b0;
                    end
                end
                S_SQUASH: begin
                    w_valid_nxt = 1'b0;
                    if (imem.imem_valid) begin
                        w_fetch_pc_nxt = r_target;
                        w_state_nxt    = S_FETCH;
                    end
                end
                S_SKID: begin
                    w_instr_nxt = r_skid_instr;
                    w_pc_nxt    = r_skid_pc;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = w_skid_hlt ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    w_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= c_RESET_PC;
            r_target     <= 16'h0000;
            r_skid_instr <= 16'h0000;
            r_skid_pc    <= 16'h0000;
            r_instr      <= 16'h0000;
            r_pc         <= 16'h0000;
            r_valid      <= 1'b0;
        end else begin
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_target     <= w_target_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_pc         <= w_pc_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    // Outputs decoded from state only
    always_comb begin
        imem.imem_req = (r_state == S_FETCH) || (r_state == S_SQUASH);
        halted        = (r_state == S_HALT);
    end

    assign imem.imem_addr = r_fetch_pc;
    assign instruction    = r_instr;
    assign pc             = r_pc;
    assign valid          = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mod_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_if
//  Description : Self-checking bench for mod_if with a reactive latency memory
//                and a queue-based fetch reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        taken;
    logic [15:0] new_pc;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic        valid;
    logic        halted;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mod_if_if u_bus ();

    mod_if u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .taken       (taken),
        .new_pc      (new_pc),
        .imem        (u_bus),
        .instruction (instruction),
        .pc          (pc),
        .valid       (valid),
        .halted      (halted)
    );

    // Memory image and response timing
    logic [15:0] mem [0:32767];
    int          lat;
    int          age;

    // Reference model of the fetch stage
    logic [15:0] m_addr;
    logic [15:0] m_target;
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;
    logic        m_halted;
    logic        m_squash;
    logic [31:0] m_skid [$];

    function automatic bit model_req();
        return !m_halted && (m_skid.size() == 0);
    endfunction

    task automatic model_reset();
        m_addr   = 16'h0000;
        m_target = 16'h0000;
        m_instr  = 16'h0000;
        m_pc     = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_squash = 1'b0;
        m_skid.delete();
        age      = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("instruction", instruction, m_instr);
        chk("pc", pc, m_pc);
        chk("valid", 16'(valid), 16'(m_valid));
        chk("halted", 16'(halted), 16'(m_halted));
        chk("imem_req", 16'(u_bus.imem_req), 16'(model_req()));
        chk("imem_addr", u_bus.imem_addr, m_addr);
    endtask

    // One clock: drive inputs, answer memory, advance model, compare
    task automatic step(input bit r, input bit s, input bit t, input logic [15:0] np);
        bit          req;
        bit          mv;
        logic [15:0] rd;
        logic [31:0] e;
        rst    = r;
        stall  = s;
        taken  = t;
        new_pc = np;
        req    = model_req();
        mv     = !r && req && (age >= lat);
        rd     = mv ? mem[m_addr[15:1]] : 16'($urandom);
        u_bus.imem_valid = mv;
        u_bus.imem_rdata = rd;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (s) begin
                if (mv && !m_squash) begin
                    m_skid.push_back({rd, m_addr + 16'd2});
                    if (rd[15:12] != 4'hF) m_addr = m_addr + 16'd2;
                end else if (mv) begin
                    m_squash = 1'b0;
                    m_addr   = m_target;
                end
            end else if (t) begin
                m_valid = 1'b0;
                m_skid.delete();
                if (mv || !req) begin
                    m_addr   = np;
                    m_halted = 1'b0;
                    m_squash = 1'b0;
                end else begin
                    m_squash = 1'b1;
                    m_target = np;
                end
            end else if (m_skid.size() != 0) begin
                e       = m_skid.pop_front();
                m_instr = e[31:16];
                m_pc    = e[15:0];
                m_valid = 1'b1;
                if (m_instr[15:12] == 4'hF) m_halted = 1'b1;
            end else if (m_halted) begin
                m_valid = 1'b0;
            end else if (m_squash) begin
                m_valid = 1'b0;
                if (mv) begin
                    m_squash = 1'b0;
                    m_addr   = m_target;
                end
            end else if (mv) begin
                m_instr = rd;
                m_pc    = m_addr + 16'd2;
                m_valid = 1'b1;
                if (rd[15:12] == 4'hF) m_halted = 1'b1;
                else m_addr = m_addr + 16'd2;
            end else begin
                m_valid = 1'b0;
            end
            if (mv || !req) age = 0;
            else age++;
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; taken = 1'b0; new_pc = 16'h0000;
        u_bus.imem_valid = 1'b0;
        u_bus.imem_rdata = 16'h0000;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom) & 16'hEFFF;
            if (i >= 64 && $urandom_range(0, 15) == 0) mem[i] = mem[i] | 16'hF000;
        end
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h2222;
        mem[3] = 16'hA001; mem[5] = 16'hBAD0; mem[8] = 16'hF000;
        mem[32767] = 16'h0777;
        model_reset();
        lat = 0;

        // Reset state, then zero-wait streaming
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("rst_valid", 16'(valid), 16'h0000);
        chk("rst_addr", u_bus.imem_addr, 16'h0000);
        chk("rst_req", 16'(u_bus.imem_req), 16'h0001);
        run(1);
        chk("zw_instr0", instruction, 16'h1234);
        chk("zw_pc0", pc, 16'h0002);
        run(1);
        chk("zw_instr1", instruction, 16'h5678);
        chk("zw_pc1", pc, 16'h0004);
        chk("zw_addr", u_bus.imem_addr, 16'h0004);

        // Latency-3 memory
        lat = 3;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(3);
        chk("lat_bubble", 16'(valid), 16'h0000);
        chk("lat_addr_held", u_bus.imem_addr, 16'h0000);
        run(1);
        chk("lat_instr", instruction, 16'h1234);
        chk("lat_valid", 16'(valid), 16'h0001);

        // Stall with skid capture of A001 at 0006
        lat = 0;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(3);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("skid_hold_instr", instruction, 16'h2222);
        chk("skid_req", 16'(u_bus.imem_req), 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        run(1);
        chk("skid_instr", instruction, 16'hA001);
        chk("skid_pc", pc, 16'h0008);
        chk("skid_next_addr", u_bus.imem_addr, 16'h0008);

        // Redirect while latency-3 request to 000A is outstanding
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(5);
        lat = 3;
        run(1);
        step(1'b0, 1'b0, 1'b1, 16'h0040);
        chk("sq_addr_held", u_bus.imem_addr, 16'h000A);
        run(2);
        chk("sq_redirect_addr", u_bus.imem_addr, 16'h0040);
        chk("sq_no_valid", 16'(valid), 16'h0000);
        run(4);
        chk("sq_target_instr", instruction, mem[32]);
        chk("sq_target_pc", pc, 16'h0042);

        // HLT at 0010 and release by taken
        lat = 0;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(9);
        chk("hlt_instr", instruction, 16'hF000);
        chk("hlt_halted", 16'(halted), 16'h0001);
        run(2);
        chk("hlt_req", 16'(u_bus.imem_req), 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0020);
        chk("hlt_release", 16'(halted), 16'h0000);
        chk("hlt_resume_addr", u_bus.imem_addr, 16'h0020);

        // PC wrap and reset during an outstanding request
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        run(1);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_addr", u_bus.imem_addr, 16'h0000);
        chk("wrap_instr", instruction, 16'h0777);
        lat = 3;
        run(2);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("midrst_valid", 16'(valid), 16'h0000);
        chk("midrst_addr", u_bus.imem_addr, 16'h0000);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) lat = $urandom_range(0, 3);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 16'($urandom) & 16'hFFFE);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
